xbar_inreq: RTL and testbench
=============================

Name: xbar_inreq

Overview:
- Input-port side of the 5x5 router crossbar; one instance sits in front of each crossbar input n.
- Buffers flits from the input VC stage and raises req/port toward the crossbar arbiters for each packet.
- Holds the request until the grant for its target output is seen, then streams the packet's flits onto idata_n/ivalid_n/ivch_n.
- Tracks downstream credits and drops req after the tail flit.

Parameters:
- DEPTH, 4, flit FIFO entries; power of 2, at least 2.
- CREDITS, 4, downstream buffer slots for the credit counter's initial and maximum value.

Ports:
- clk  in  1  clock.
- rst_  in  1  reset, synchronous, active-high.
- wdata  in  `DATAW+1  flit from input VC stage.
- wvalid  in  1  write strobe.
- wftype  in  2  00 body, 01 head, 10 tail, 11 head+tail (single-flit packet).
- wport  in  `PORTW+1  routed output port; meaningful on head flits only.
- wvch  in  `VCHW+1  output VC; head flits only.
- wmultab  in  1  multicast/absorb flag; head flits only.
- wready  out  1  FIFO can accept a flit.
- idata  out  `DATAW+1  flit to crossbar.
- ivalid  out  1  flit valid to crossbar.
- ivch  out  `VCHW+1  VC of the flit.
- port  out  `PORTW+1  requested output port.
- req  out  1  crossbar request.
- grt  in  `PORT+1  one-hot grant vector; bit k means output k selects this input.
- multab  out  1  multicast/absorb flag of the current packet.
- crd_in  in  1  one credit returned from downstream.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst_=1 at a clk edge):
  - FIFO flushed; state IDLE; credit count = CREDITS; err = 0.
  - req, ivalid, port, ivch, multab and idata all 0. wready = 0 while rst_=1.
  - A reset mid-packet discards the packet with no tail emitted. req and ivalid are 0 from the first edge with rst_=1.
- FIFO:
  - Entries hold {wdata, wftype, wport, wvch, wmultab}.
  - wready = !full. A write occurs when wvalid && wready.
  - Pointers are log2(DEPTH) bits plus a wrap bit; full/empty are decided from the wrap bits.
  - Pop and push in the same cycle are allowed. A write on full is ignored and does not set err.
  - No bypass: a flit written at edge t is visible as head in cycle t+1.
- FSM states IDLE and ACTIVE:
  - IDLE, head is head/head+tail: latch port_q=wport, vch_q=wvch, multab_q=wmultab from the head entry; go to ACTIVE at the next edge. The flit is not popped.
  - IDLE, head is body/tail: pop it, set err, stay IDLE.
  - IDLE, empty: stay.
  - ACTIVE: req=1, port=port_q, multab=multab_q, ivch=vch_q.
- Send condition: send = ACTIVE && grt[port_q] && !empty && credits>0.
  - On send: ivalid=1 and idata=head data combinationally in that cycle; the flit is popped at the edge.
  - grt bits other than port_q are ignored. If grt[port_q]=1 but the FIFO is empty or credits=0, ivalid=0 and req stays 1.
- Leaving ACTIVE: a send of a tail or head+tail flit returns the FSM to IDLE, and req=0 in the following cycle.
  - A head flit arriving as head while ACTIVE (missing tail) sets err and is sent as data. The packet continues until a tail.
- Outside ACTIVE: ivalid=0 and idata=0.
- Credit counter (width clog2(CREDITS+1)):
  - -1 on send, +1 on crd_in, unchanged when both occur in the same cycle.
  - crd_in at CREDITS without a send saturates and sets err.
- Latency: a head written at edge t gives req=1 at t+2 at the earliest. ivalid follows in the first cycle where grt[port_q]=1 with a credit available.
- Throughput: 1 flit/cycle while grant and credits are held.
- err clears only on reset.

Decomposition:
- Flit type encodings (FT_BODY, FT_HEAD, FT_TAIL, FT_HT) and FSM state codes are added to define.h next to the existing width macros.
- One sub-module, xbar_inreq_fifo (parameterised DEPTH/width synchronous FIFO). FSM and credit logic stay in the top.

Test Plan:
- Single-flit packet, wftype=11, wport=2, wmultab=0, CREDITS=4; grt=5'b00100 held -> req=1 at t+2 with port=2 and ivalid=1 in the same cycle; req=0 next cycle; credits=3.
- 4-flit packet (head, body, body, tail) to port 3; grt[3] withheld 5 cycles, then held -> req stays 1 with ivalid=0 while waiting, then 4 consecutive ivalid cycles; grt[1]=1 alone never yields ivalid.
- CREDITS=2, 4-flit packet, grt held, no crd_in -> 2 flits sent, then req=1 and ivalid=0; one crd_in pulse -> exactly one more flit.
- Fill FIFO (DEPTH=4) with no grant -> wready=0 after the 4th write and a 5th write is ignored; a send and a write in the same cycle keep count at 4.
- Body flit arriving in IDLE -> popped, err=1, req stays 0; crd_in at full credits -> err=1; both cleared only by rst_.
- rst_ asserted mid-packet after 2 of 4 flits -> req=0 and ivalid=0 from the next edge; FIFO empty; credits=CREDITS; a new packet after reset is sent normally.

Source files
------------

// File: rtl/xbar_inreq_pkg.sv
// Shared widths, flit-type and FSM encodings, and the buffered flit layout.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DATAW/PORTW/VCHW/PORT - most-significant bit indices of the data, port, VC
//                           and grant vectors (width = value + 1)
//   ftype_e               - flit type carried alongside each flit
//   state_e               - input-request FSM states
//   flit_t                - one flit FIFO entry
package xbar_inreq_pkg;

  localparam int DATAW = 31;  // idata/wdata are 32 bits
  localparam int PORTW = 2;   // port index is 3 bits (5 outputs)
  localparam int VCHW  = 1;   // output VC is 2 bits
  localparam int PORT  = 4;   // grant vector is 5 bits, one per output

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10,
    FT_HT   = 2'b11   // single-flit packet: head and tail at once
  } ftype_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATAW:0] data;
    ftype_e         ftype;
    logic [PORTW:0] port;
    logic [VCHW:0]  vch;
    logic           multab;
  } flit_t;

  // Bit 0 of the encoding marks a packet start, bit 1 a packet end.
  function automatic logic is_head(input ftype_e f);
    return f[0];
  endfunction

  function automatic logic is_tail(input ftype_e f);
    return f[1];
  endfunction

endpackage

// File: rtl/xbar_inreq_fifo.sv
// Generic synchronous flit FIFO, DEPTH entries of W bits, no write-through bypass.
// Latency: an entry pushed at edge t is presented on dout from cycle t+1.
// Backpressure: full refuses pushes (silently dropped); pop on empty is ignored.
//
// Ports:
//   clk, rst        - clock, synchronous active-high flush
//   push, din       - write request and entry
//   pop             - remove the head entry at the next edge
//   dout            - current head entry (valid when !empty)
//   full, empty     - occupancy flags
module xbar_inreq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty are
  // distinguishable when the index bits coincide.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing reads it until the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/xbar_inreq.sv
// Crossbar input-side requester: buffers flits, requests an output, streams the packet on grant.
// Latency: head written at edge t raises req after edge t+1; flits leave combinationally on grant+credit.
// Backpressure: wready drops when the FIFO is full; sending stalls on missing grant or zero credits.
//
// Ports:
//   clk, rst_                      - clock, synchronous active-high reset
//   wdata/wvalid/wftype/wport/
//   wvch/wmultab, wready           - flit input from the VC stage
//   idata/ivalid/ivch              - flit output to the crossbar
//   port/req/multab                - request toward the output arbiters
//   grt                            - one-hot grant, bit k = output k picked us
//   crd_in                         - one downstream credit returned
//   err                            - sticky protocol error
module xbar_inreq
  import xbar_inreq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [DATAW:0] wdata,
  input  logic           wvalid,
  input  logic [1:0]     wftype,
  input  logic [PORTW:0] wport,
  input  logic [VCHW:0]  wvch,
  input  logic           wmultab,
  output logic           wready,
  output logic [DATAW:0] idata,
  output logic           ivalid,
  output logic [VCHW:0]  ivch,
  output logic [PORTW:0] port,
  output logic           req,
  input  logic [PORT:0]  grt,
  output logic           multab,
  input  logic           crd_in,
  output logic           err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = PORTW + 1;

  flit_t          wr_flit;
  flit_t          head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  state_e         state_q, state_d;
  logic [PORTW:0] port_q;
  logic [VCHW:0]  vch_q;
  logic           multab_q;
  logic           head_sent_q;  // current packet's opening flit already went out
  logic [CW-1:0]  crd_q;
  logic           err_q;

  logic           latch;
  logic           send;
  logic           gnt_hit;
  logic           proto_err;
  logic           crd_ovf;

  // ------------------------------------------------------------------
  // Flit buffer
  // ------------------------------------------------------------------
  assign wr_flit = '{data:   wdata,
                     ftype:  ftype_e'(wftype),
                     port:   wport,
                     vch:    wvch,
                     multab: wmultab};

  assign wready = !fifo_full && !rst_;

  xbar_inreq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(flit_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_),
    .push  (wvalid && wready),
    .din   (wr_flit),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ------------------------------------------------------------------
  // Grant decode: only the grant bit for our latched port matters.
  // Written as a compare loop so a port code beyond the grant vector
  // simply never matches.
  // ------------------------------------------------------------------
  always_comb begin
    gnt_hit = 1'b0;
    for (int k = 0; k <= PORT; k++) begin
      if (port_q == PW'(k)) gnt_hit = grt[k];
    end
  end

  // ------------------------------------------------------------------
  // FSM next-state and outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    pop       = 1'b0;
    send      = 1'b0;
    proto_err = 1'b0;
    req       = 1'b0;
    ivalid    = 1'b0;
    idata     = '0;
    port      = '0;
    ivch      = '0;
    multab    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_head(head.ftype)) begin
            // The head stays in the FIFO; it is the first flit sent.
            latch   = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            // Stray body/tail with no open packet: discard it.
            pop       = 1'b1;
            proto_err = 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        req    = 1'b1;
        port   = port_q;
        ivch   = vch_q;
        multab = multab_q;
        if (gnt_hit && !fifo_empty && (crd_q != '0)) begin
          send   = 1'b1;
          pop    = 1'b1;
          ivalid = 1'b1;
          idata  = head.data;
          // A second head inside an open packet means the tail was lost;
          // it is forwarded as ordinary payload.
          if (is_head(head.ftype) && head_sent_q) proto_err = 1'b1;
          if (is_tail(head.ftype)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Credit return with the counter already at its ceiling.
  assign crd_ovf = crd_in && !send && (crd_q == CW'(CREDITS));

  // ------------------------------------------------------------------
  // State, packet context, credits, error
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q     <= ST_IDLE;
      port_q      <= '0;
      vch_q       <= '0;
      multab_q    <= 1'b0;
      head_sent_q <= 1'b0;
      crd_q       <= CW'(CREDITS);
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (latch) begin
        port_q      <= head.port;
        vch_q       <= head.vch;
        multab_q    <= head.multab;
        head_sent_q <= 1'b0;
      end else if (send) begin
        head_sent_q <= !is_tail(head.ftype);
      end

      // A send and a returned credit in the same cycle cancel out.
      if (send && !crd_in) begin
        crd_q <= crd_q - CW'(1);
      end else if (crd_in && !send && !crd_ovf) begin
        crd_q <= crd_q + CW'(1);
      end

      if (proto_err || crd_ovf) err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_xbar_inreq.sv
// Directed testbench for xbar_inreq: two instances (CREDITS=4 and CREDITS=2) share all inputs.
// Inputs change 1 time unit after each rising edge; outputs are sampled 3 units later.
module tb_xbar_inreq;

  logic        clk;
  logic        rst_;
  logic [31:0] wdata;
  logic        wvalid;
  logic [1:0]  wftype;
  logic [2:0]  wport;
  logic [1:0]  wvch;
  logic        wmultab;
  logic [4:0]  grt;
  logic        crd_in;

  logic        wready, ivalid, req, multab, err;
  logic [31:0] idata;
  logic [1:0]  ivch;
  logic [2:0]  port;

  logic        b_wready, b_ivalid, b_req, b_multab, b_err;
  logic [31:0] b_idata;
  logic [1:0]  b_ivch;
  logic [2:0]  b_port;

  int n_tests;
  int n_fail;

  xbar_inreq #(.DEPTH(4), .CREDITS(4)) dut (
    .clk(clk), .rst_(rst_), .wdata(wdata), .wvalid(wvalid), .wftype(wftype),
    .wport(wport), .wvch(wvch), .wmultab(wmultab), .wready(wready),
    .idata(idata), .ivalid(ivalid), .ivch(ivch), .port(port), .req(req),
    .grt(grt), .multab(multab), .crd_in(crd_in), .err(err)
  );

  xbar_inreq #(.DEPTH(4), .CREDITS(2)) dut2 (
    .clk(clk), .rst_(rst_), .wdata(wdata), .wvalid(wvalid), .wftype(wftype),
    .wport(wport), .wvch(wvch), .wmultab(wmultab), .wready(b_wready),
    .idata(b_idata), .ivalid(b_ivalid), .ivch(b_ivch), .port(b_port), .req(b_req),
    .grt(grt), .multab(b_multab), .crd_in(crd_in), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic quiet();
    wvalid = 1'b0; grt = '0; crd_in = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_ = 1'b1;
    nxt();
    nxt();
    rst_ = 1'b0;
  endtask

  task automatic set_flit(input logic [31:0] d, input logic [1:0] ft,
                          input logic [2:0] p, input logic [1:0] vc, input logic m);
    wvalid = 1'b1; wdata = d; wftype = ft; wport = p; wvch = vc; wmultab = m;
  endtask

  task automatic wr(input logic [31:0] d, input logic [1:0] ft,
                    input logic [2:0] p, input logic [1:0] vc, input logic m);
    set_flit(d, ft, p, vc, m);
    nxt();
    wvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    set_flit(32'hDEAD_BEEF, 2'b01, 3'd1, 2'd1, 1'b1);
    grt = 5'b11111;
    nxt();
    nxt();
    smp();
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req); end
    n_tests++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid: got %b want 0", ivalid); end
    n_tests++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b want 0", wready); end
    n_tests++; if ({err, port, ivch, multab, idata} !== 39'd0) begin n_fail++;
      $display("FAIL rst_outs: err=%b port=%0d ivch=%0d multab=%b idata=%h want all 0", err, port, ivch, multab, idata); end
    quiet();
    nxt();
    rst_ = 1'b0;
    smp();
    n_tests++; if (wready !== 1'b1) begin n_fail++; $display("FAIL rst_release_wready: got %b want 1", wready); end
  endtask

  task automatic test_single();
    do_reset();
    set_flit(32'hA5A5_0001, 2'b11, 3'd2, 2'd1, 1'b0);
    grt = 5'b00100;
    nxt();
    wvalid = 1'b0;
    smp();
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", req); end
    nxt();
    smp();
    n_tests++; if ({req, port, ivalid} !== {1'b1, 3'd2, 1'b1}) begin n_fail++;
      $display("FAIL single_req: req=%b port=%0d ivalid=%b want 1 2 1", req, port, ivalid); end
    n_tests++; if ({idata, ivch, multab} !== {32'hA5A5_0001, 2'd1, 1'b0}) begin n_fail++;
      $display("FAIL single_data: idata=%h ivch=%0d multab=%b want a5a50001 1 0", idata, ivch, multab); end
    nxt();
    smp();
    n_tests++; if ({req, ivalid} !== 2'b00) begin n_fail++;
      $display("FAIL single_drop: req=%b ivalid=%b want 0 0", req, ivalid); end
    // Three credits remain: one return fills up cleanly, the next overflows.
    grt = '0;
    crd_in = 1'b1;
    nxt();
    crd_in = 1'b0;
    smp();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_crd3: err=%b want 0", err); end
    crd_in = 1'b1;
    nxt();
    crd_in = 1'b0;
    smp();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL single_crd4_ovf: err=%b want 1", err); end
  endtask

  task automatic test_wait_grant();
    logic [31:0] d [4];
    d[0] = 32'h3000_0000; d[1] = 32'h3000_0011; d[2] = 32'h3000_0022; d[3] = 32'h3000_0033;
    do_reset();
    grt = 5'b00010;  // wrong output granted the whole time
    wr(d[0], 2'b01, 3'd3, 2'd2, 1'b1);
    wr(d[1], 2'b00, 3'd0, 2'd0, 1'b0);
    wr(d[2], 2'b00, 3'd0, 2'd0, 1'b0);
    wr(d[3], 2'b10, 3'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      smp();
      n_tests++; if ({req, ivalid, port, multab, ivch} !== {1'b1, 1'b0, 3'd3, 1'b1, 2'd2}) begin n_fail++;
        $display("FAIL wait_hold[%0d]: req=%b ivalid=%b port=%0d multab=%b ivch=%0d want 1 0 3 1 2",
                 i, req, ivalid, port, multab, ivch); end
      nxt();
    end
    grt = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      smp();
      n_tests++; if ({ivalid, idata} !== {1'b1, d[i]}) begin n_fail++;
        $display("FAIL wait_stream[%0d]: ivalid=%b idata=%h want 1 %h", i, ivalid, idata, d[i]); end
      nxt();
    end
    smp();
    n_tests++; if ({req, ivalid} !== 2'b00) begin n_fail++;
      $display("FAIL wait_end: req=%b ivalid=%b want 0 0", req, ivalid); end
  endtask

  task automatic test_credits();
    logic [31:0] d [4];
    d[0] = 32'h4000_0000; d[1] = 32'h4000_0001; d[2] = 32'h4000_0002; d[3] = 32'h4000_0003;
    do_reset();
    wr(d[0], 2'b01, 3'd4, 2'd0, 1'b0);
    wr(d[1], 2'b00, 3'd0, 2'd0, 1'b0);
    wr(d[2], 2'b00, 3'd0, 2'd0, 1'b0);
    wr(d[3], 2'b10, 3'd0, 2'd0, 1'b0);
    grt = 5'b10000;
    for (int i = 0; i < 2; i++) begin
      smp();
      n_tests++; if ({b_ivalid, b_idata} !== {1'b1, d[i]}) begin n_fail++;
        $display("FAIL crd_send[%0d]: ivalid=%b idata=%h want 1 %h", i, b_ivalid, b_idata, d[i]); end
      nxt();
    end
    for (int i = 0; i < 2; i++) begin
      smp();
      n_tests++; if ({b_req, b_ivalid} !== 2'b10) begin n_fail++;
        $display("FAIL crd_stall[%0d]: req=%b ivalid=%b want 1 0", i, b_req, b_ivalid); end
      if (i == 0) nxt();
    end
    crd_in = 1'b1;
    nxt();
    crd_in = 1'b0;
    smp();
    n_tests++; if ({b_ivalid, b_idata} !== {1'b1, d[2]}) begin n_fail++;
      $display("FAIL crd_refill: ivalid=%b idata=%h want 1 %h", b_ivalid, b_idata, d[2]); end
    nxt();
    smp();
    n_tests++; if ({b_req, b_ivalid, b_err} !== 3'b100) begin n_fail++;
      $display("FAIL crd_one_only: req=%b ivalid=%b err=%b want 1 0 0", b_req, b_ivalid, b_err); end
  endtask

  task automatic test_full();
    logic [31:0] d [4];
    d[0] = 32'h5000_0000; d[1] = 32'h5000_0001; d[2] = 32'h5000_0002; d[3] = 32'h5000_0003;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(d[i], (i == 0) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b00), 3'd2, 2'd0, 1'b0);
      smp();
      n_tests++; if (wready !== (i < 3)) begin n_fail++;
        $display("FAIL full_wready[%0d]: got %b want %b", i, wready, (i < 3)); end
      #2;
    end
    wr(32'hBAD0_BAD0, 2'b00, 3'd0, 2'd0, 1'b0);  // refused: FIFO full
    smp();
    n_tests++; if ({wready, err} !== 2'b00) begin n_fail++;
      $display("FAIL full_ignored: wready=%b err=%b want 0 0", wready, err); end
    #2;
    grt = 5'b00100;
    smp();
    n_tests++; if ({ivalid, idata} !== {1'b1, d[0]}) begin n_fail++;
      $display("FAIL full_pop0: ivalid=%b idata=%h want 1 %h", ivalid, idata, d[0]); end
    nxt();
    set_flit(32'h5100_0000, 2'b01, 3'd2, 2'd0, 1'b0);  // send and write together
    smp();
    n_tests++; if ({wready, ivalid, idata} !== {1'b1, 1'b1, d[1]}) begin n_fail++;
      $display("FAIL full_pushpop: wready=%b ivalid=%b idata=%h want 1 1 %h", wready, ivalid, idata, d[1]); end
    nxt();
    grt = '0;
    set_flit(32'h5100_0001, 2'b10, 3'd0, 2'd0, 1'b0);
    smp();
    n_tests++; if (wready !== 1'b1) begin n_fail++; $display("FAIL full_count3: wready=%b want 1", wready); end
    nxt();
    wvalid = 1'b0;
    smp();
    n_tests++; if (wready !== 1'b0) begin n_fail++; $display("FAIL full_count4: wready=%b want 0", wready); end
    #2;
    grt = 5'b00100;
    for (int i = 2; i < 4; i++) begin
      smp();
      n_tests++; if ({ivalid, idata} !== {1'b1, d[i]}) begin n_fail++;
        $display("FAIL full_drain[%0d]: ivalid=%b idata=%h want 1 %h", i, ivalid, idata, d[i]); end
      nxt();
    end
    crd_in = 1'b1;  // credits were all spent; return one during the idle cycle
    smp();
    n_tests++; if ({req, ivalid} !== 2'b00) begin n_fail++;
      $display("FAIL full_gap: req=%b ivalid=%b want 0 0", req, ivalid); end
    nxt();
    crd_in = 1'b0;
    smp();
    n_tests++; if ({ivalid, idata} !== {1'b1, 32'h5100_0000}) begin n_fail++;
      $display("FAIL full_next_head: ivalid=%b idata=%h want 1 51000000", ivalid, idata); end
    nxt();
    smp();
    n_tests++; if ({req, ivalid} !== 2'b10) begin n_fail++;
      $display("FAIL full_no_credit: req=%b ivalid=%b want 1 0", req, ivalid); end
  endtask

  task automatic test_errors();
    do_reset();
    wr(32'h6000_0000, 2'b00, 3'd1, 2'd0, 1'b0);  // body with no open packet
    smp();
    n_tests++; if ({req, err} !== 2'b00) begin n_fail++;
      $display("FAIL err_body_pre: req=%b err=%b want 0 0", req, err); end
    nxt();
    smp();
    n_tests++; if ({req, err} !== 2'b01) begin n_fail++;
      $display("FAIL err_body: req=%b err=%b want 0 1", req, err); end
    nxt(); nxt(); nxt();
    smp();
    n_tests++; if ({req, err, wready} !== 3'b011) begin n_fail++;
      $display("FAIL err_sticky: req=%b err=%b wready=%b want 0 1 1", req, err, wready); end
    do_reset();
    smp();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear1: err=%b want 0", err); end
    crd_in = 1'b1;
    nxt();
    crd_in = 1'b0;
    smp();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_crd_ovf: err=%b want 1", err); end
    do_reset();
    smp();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear2: err=%b want 0", err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(32'h7000_0000, 2'b01, 3'd1, 2'd3, 1'b0);
    wr(32'h7000_0001, 2'b00, 3'd0, 2'd0, 1'b0);
    wr(32'h7000_0002, 2'b00, 3'd0, 2'd0, 1'b0);
    wr(32'h7000_0003, 2'b10, 3'd0, 2'd0, 1'b0);
    grt = 5'b00010;
    nxt();
    smp();
    n_tests++; if ({ivalid, idata} !== {1'b1, 32'h7000_0001}) begin n_fail++;
      $display("FAIL mrst_second: ivalid=%b idata=%h want 1 70000001", ivalid, idata); end
    nxt();
    rst_ = 1'b1;
    nxt();
    smp();
    n_tests++; if ({req, ivalid} !== 2'b00) begin n_fail++;
      $display("FAIL mrst_drop: req=%b ivalid=%b want 0 0", req, ivalid); end
    rst_ = 1'b0;
    nxt();
    smp();
    n_tests++; if ({req, ivalid, wready} !== 3'b001) begin n_fail++;
      $display("FAIL mrst_empty: req=%b ivalid=%b wready=%b want 0 0 1", req, ivalid, wready); end
    #2;
    wr(32'h7100_0000, 2'b11, 3'd1, 2'd2, 1'b1);
    nxt();
    smp();
    n_tests++; if ({req, ivalid, idata, ivch, multab} !== {1'b1, 1'b1, 32'h7100_0000, 2'd2, 1'b1}) begin n_fail++;
      $display("FAIL mrst_new_pkt: req=%b ivalid=%b idata=%h ivch=%0d multab=%b want 1 1 71000000 2 1",
               req, ivalid, idata, ivch, multab); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_    = 1'b1;
    wdata   = '0; wftype = '0; wport = '0; wvch = '0; wmultab = 1'b0;
    quiet();
    test_reset();
    test_single();
    test_wait_grant();
    test_credits();
    test_full();
    test_errors();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
